// File: rtl/omsp_spm_key_sched_pkg.sv
// Shared definitions for the SM key load scheduler.
// Optional feature macro: OMSP_SPM_KEY_CLEAR_EN (zeroize the key slot on abort/timeout).
package omsp_spm_key_sched_pkg;

  localparam int unsigned WORD_BITS    = 16;
  localparam int unsigned KEY_BITS_DEF = 64;
  localparam int unsigned TIMEOUT_DEF  = 255;
  localparam int unsigned TO_CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_LOAD = 3'd2,
    ST_FIN  = 3'd3,
    ST_CLR  = 3'd4
  } state_t;

  function automatic int unsigned key_words(input int unsigned key_bits);
    return key_bits / WORD_BITS;
  endfunction

  localparam int unsigned KEY_WORDS_DEF = key_words(KEY_BITS_DEF);

endpackage

// File: rtl/omsp_spm_key_sched.sv
// SM key load scheduler: starts key derivation, accepts key words over a
// valid/ready handshake and writes them one per cycle into the key array.
// Optional feature macro: OMSP_SPM_KEY_CLEAR_EN -- on abort/timeout the key
// slot is overwritten with zeros (CLR state) before returning to IDLE.
module omsp_spm_key_sched
  import omsp_spm_key_sched_pkg::*;
#(
  parameter int unsigned KEY_BITS     = KEY_BITS_DEF,
  parameter int unsigned KEY_IDX_SIZE = 2,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                    mclk,
  input  logic                    puc_rst_n,
  input  logic                    req_start,
  input  logic                    req_abort,
  output logic                    crypto_start,
  input  logic                    kw_valid,
  input  logic [15:0]             kw_data,
  output logic                    kw_ready,
  output logic                    write_key,
  output logic [15:0]             key_in,
  output logic [KEY_IDX_SIZE-1:0] key_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned               KEY_WORDS = key_words(KEY_BITS);
  localparam logic [KEY_IDX_SIZE-1:0]   LAST_IDX  = KEY_IDX_SIZE'(KEY_WORDS - 1);
  localparam logic [TO_CNT_W-1:0]       TO_LIMIT  = TO_CNT_W'(TIMEOUT);

`ifdef OMSP_SPM_KEY_CLEAR_EN
  localparam state_t FAIL_TGT = ST_CLR;
`else
  localparam state_t FAIL_TGT = ST_IDLE;
`endif

  state_t                  state_q, state_d;
  logic [KEY_IDX_SIZE-1:0] cnt_q, cnt_d;
  logic [TO_CNT_W-1:0]     to_q, to_d;
  logic                    err_q, err_d;
  logic                    wr_q, wr_d;
  logic [15:0]             key_in_q, key_in_d;
  logic [KEY_IDX_SIZE-1:0] key_idx_q, key_idx_d;
  logic                    xfer;

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      to_q      <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      key_in_q  <= '0;
      key_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      key_in_q  <= key_in_d;
      key_idx_q <= key_idx_d;
    end
  end

  // Handshake: abort suppresses ready so a same-cycle word is never written
  always_comb begin
    kw_ready = (state_q == ST_LOAD) && !req_abort;
    xfer     = kw_valid && kw_ready;
  end

  // Next-state, counters and key array write staging
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    err_d     = err_q;
    wr_d      = 1'b0;
    key_in_d  = key_in_q;
    key_idx_d = key_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (req_start && !req_abort) begin
          state_d = ST_REQ;
          err_d   = 1'b0;
          cnt_d   = '0;
          to_d    = '0;
        end
      end

      ST_REQ: begin
        if (req_abort) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = FAIL_TGT;
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (req_abort) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = FAIL_TGT;
        end else if (xfer) begin
          wr_d      = 1'b1;
          key_in_d  = kw_data;
          key_idx_d = cnt_q;
          to_d      = '0;
          // last word holds the counter instead of wrapping it
          if (cnt_q == LAST_IDX) state_d = ST_FIN;
          else                   cnt_d   = cnt_q + 1'b1;
        end else if (to_q + 1'b1 == TO_LIMIT) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = FAIL_TGT;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

`ifdef OMSP_SPM_KEY_CLEAR_EN
      ST_CLR: begin
        wr_d      = 1'b1;
        key_in_d  = '0;
        key_idx_d = cnt_q;
        if (cnt_q == LAST_IDX) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs decoded from state; write port driven from registers
  always_comb begin
    crypto_start = (state_q == ST_REQ);
    done         = (state_q == ST_FIN);
    busy         = (state_q != ST_IDLE);
    error        = err_q;
    write_key    = wr_q;
    key_in       = key_in_q;
    key_idx      = key_idx_q;
  end

endmodule
